mem_stall_ctrl: RTL and testbench
=================================

# mem_stall_ctrl

Pipeline sequencing controller for the 5-stage CPU's memory stage and hazard interlock. It drives a multi-cycle data memory over a req/ack handshake on behalf of the instruction held in the EX/MEM pipeline register. While that access is outstanding it freezes every pipeline register, and it inserts load-use bubbles into ID/EX. It sits between the EX/MEM register, the data memory and the PC / IF_ID / ID_EX / EX_MEM enables.

## Interface
Parameters:
- TIMEOUT, default 16: maximum BUSY cycles without ack before the access is abandoned (≥2).
- CNT_W, default 5: timeout counter width; must hold TIMEOUT.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- MemRead_i  in  1  EX/MEM load flag.
- MemWrite_i  in  1  EX/MEM store flag.
- addr_i  in  32  EX/MEM ALU result (byte address).
- data_i  in  32  EX/MEM store data.
- mem_ack_i  in  1  data memory completion, one-cycle pulse.
- mem_rdata_i  in  32  data memory read data, valid with mem_ack_i.
- IDEX_MemRead_i  in  1  ID/EX load flag.
- IDEX_RD_i  in  5  ID/EX destination register.
- IFID_RS1_i  in  5  IF/ID source register 1.
- IFID_RS2_i  in  5  IF/ID source register 2.
- mem_req_o  out  1  memory request (registered).
- mem_we_o  out  1  1 = write (registered).
- mem_addr_o  out  32  latched address.
- mem_wdata_o  out  32  latched store data.
- rdata_o  out  32  load data for MEM/WB.
- mem_valid_o  out  1  rdata_o valid / access complete this cycle.
- stall_o  out  1  freeze PC, IF_ID, ID_EX, EX_MEM; bubble into MEM/WB.
- hold_o  out  1  freeze PC and IF_ID only.
- bubble_o  out  1  zero ID/EX control signals.
- err_o  out  1  sticky timeout flag.

## Operation
FSM with three states:
- IDLE: if MemRead_i|MemWrite_i, latch addr_i/data_i/MemWrite_i into the mem_* registers and go to BUSY. stall_o is combinationally 1 in that cycle.
- BUSY: mem_req_o=1, stall_o=1, counter increments.
  - mem_ack_i=1: capture mem_rdata_i into rdata_o (loads only; stores leave rdata_o unchanged) and go to DONE.
  - counter = TIMEOUT-1 with no ack: set err_o, rdata_o=0, go to DONE.
- DONE: mem_req_o=0, stall_o=0, mem_valid_o=1. The pipeline advances on this edge and the state returns to IDLE unconditionally. The same EX/MEM instruction is therefore never reissued.

Rules:
- Load-use: bubble_o = IDEX_MemRead_i & (IDEX_RD_i≠0) & (IDEX_RD_i==IFID_RS1_i | IDEX_RD_i==IFID_RS2_i) & ~stall_o.
- hold_o = bubble_o | stall_o. stall_o has priority; bubble_o is evaluated once the stall releases.
- Simultaneous MemRead_i and MemWrite_i is treated as a write.
- mem_ack_i outside BUSY is ignored.
- Counter clears on entry to BUSY. Counter arithmetic is unsigned and does not wrap while in BUSY.
- err_o clears only on reset.

## Timing
- Reset values: state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, mem_valid_o=0, err_o=0, counter=0. stall_o, hold_o and bubble_o follow combinationally from these values and the inputs.
- Access seen in EX/MEM at cycle 0: req from cycle 1. Ack in cycle k≥1 gives DONE in cycle k+1. Stall cycles = k+1; minimum 2.
- Back-to-back memory instructions: the next one enters EX/MEM at the DONE edge, is seen in IDLE the following cycle, and has no idle gap in stall beyond the DONE cycle.
- Reset asserted mid-BUSY: mem_req_o drops immediately (asynchronous). The outstanding access is abandoned and no mem_valid_o is produced.
- mem_addr_o, mem_wdata_o and mem_we_o are stable throughout BUSY.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - state enum {IDLE, BUSY, DONE};
  - REG_ZERO = 5'd0;
  - NOP control constant.
- One natural sub-module: `hazard_detect`, the combinational load-use comparator producing the raw bubble. The FSM, counter and latches stay in the top module.

## Test plan
- Load at addr 0x40, ack in first BUSY cycle with rdata 0xDEADBEEF → stall_o high exactly 2 cycles; mem_valid_o=1 and rdata_o=0xDEADBEEF in the DONE cycle; mem_we_o=0.
- Store data 0x12345678 to 0x80, ack after 4 BUSY cycles → req held 4 cycles with addr/wdata stable, mem_we_o=1, 5 stall cycles, rdata_o unchanged.
- No ack, TIMEOUT=16 → req for 16 cycles, then err_o=1 sticky, rdata_o=0, DONE once, return to IDLE.
- IDEX_MemRead_i=1, IDEX_RD_i=5, IFID_RS2_i=5 → bubble_o=1 and hold_o=1 for one cycle. Same case with IDEX_RD_i=0 → bubble_o=0. Same case during stall → bubble_o=0 until release.
- rst_i pulsed mid-BUSY → mem_req_o=0 within the same cycle, state IDLE, no mem_valid_o. A later ack pulse is ignored.
- Two consecutive loads, each acked at the first opportunity → two separate req bursts, each followed by one DONE cycle, with no duplicate request for either instruction.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing / hazard control logic.
package pipe_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // ID/EX control bundle; NOP is what a bubble turns it into.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } idex_ctrl_t;

  localparam idex_ctrl_t NOP = '0;

endpackage

// File: rtl/mem_stall_ctrl_hazard_detect.sv
// Load-use comparator: raw bubble request before stall masking.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             idex_mem_read_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic [REG_W-1:0] ifid_rs1_i,
  input  logic [REG_W-1:0] ifid_rs2_i,
  output logic             bubble_o
);

  assign bubble_o = idex_mem_read_i && (idex_rd_i != REG_ZERO) &&
                    ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

endmodule

// File: rtl/mem_stall_ctrl.sv
// Memory-stage sequencer: drives the multi-cycle data memory, freezes the
// pipeline while an access is outstanding and inserts load-use bubbles.
module mem_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [XLEN-1:0]  data_i,
  input  logic             mem_ack_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic             IDEX_MemRead_i,
  input  logic [REG_W-1:0] IDEX_RD_i,
  input  logic [REG_W-1:0] IFID_RS1_i,
  input  logic [REG_W-1:0] IFID_RS2_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  output logic [XLEN-1:0]  rdata_o,
  output logic             mem_valid_o,
  output logic             stall_o,
  output logic             hold_o,
  output logic             bubble_o,
  output logic             err_o
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             access;
  logic             raw_bubble;

  assign access  = MemRead_i | MemWrite_i;
  assign cnt_d   = cnt_q + CNT_W'(1);
  assign stall_o = (state_q == BUSY) || ((state_q == IDLE) && access);

  hazard_detect u_hazard_detect (
    .idex_mem_read_i (IDEX_MemRead_i),
    .idex_rd_i       (IDEX_RD_i),
    .ifid_rs1_i      (IFID_RS1_i),
    .ifid_rs2_i      (IFID_RS2_i),
    .bubble_o        (raw_bubble)
  );

  // Stall wins; the load-use check only takes effect once the pipeline moves.
  assign bubble_o = raw_bubble & ~stall_o;
  assign hold_o   = bubble_o | stall_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
      mem_valid_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_valid_o <= 1'b0;
          if (access) begin
            mem_addr_o  <= addr_i;
            mem_wdata_o <= data_i;
            mem_we_o    <= MemWrite_i;
            mem_req_o   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            if (!mem_we_o) begin
              rdata_o <= mem_rdata_i;
            end
            mem_req_o   <= 1'b0;
            mem_valid_o <= 1'b1;
            state_q     <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_o       <= 1'b1;
            rdata_o     <= '0;
            mem_req_o   <= 1'b0;
            mem_valid_o <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        // Pipeline advances on this edge, so the instruction is never reissued.
        DONE: begin
          mem_valid_o <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          mem_req_o   <= 1'b0;
          mem_valid_o <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Randomized self-checking bench for mem_stall_ctrl against a cycle-count model.
module tb_mem_stall_ctrl;

  localparam int unsigned T = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, data_i;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RD_i, IFID_RS1_i, IFID_RS2_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;
  logic        mem_valid_o, stall_o, hold_o, bubble_o, err_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_rdata;
  bit          model_err;

  mem_stall_ctrl #(.TIMEOUT(T), .CNT_W(5)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .MemRead_i      (MemRead_i),
    .MemWrite_i     (MemWrite_i),
    .addr_i         (addr_i),
    .data_i         (data_i),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_RD_i      (IDEX_RD_i),
    .IFID_RS1_i     (IFID_RS1_i),
    .IFID_RS2_i     (IFID_RS2_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .rdata_o        (rdata_o),
    .mem_valid_o    (mem_valid_o),
    .stall_o        (stall_o),
    .hold_o         (hold_o),
    .bubble_o       (bubble_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit load_use();
    return IDEX_MemRead_i && (IDEX_RD_i != 5'd0) &&
           ((IDEX_RD_i == IFID_RS1_i) || (IDEX_RD_i == IFID_RS2_i));
  endfunction

  // One access: ack_at is the cycle (counted from the IDLE cycle = 0) where ack
  // pulses; 0 means never. Latency saturates at T, after which it times out.
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input int ack_at,
                            input logic [31:0] rdv);
    int          lat;
    bit          tmo;
    bit          e_stall, e_req, e_valid, e_bub;
    logic [31:0] ack_data;
    lat = (ack_at >= 1 && ack_at <= int'(T)) ? ack_at : int'(T);
    tmo = (lat != ack_at);
    ack_data = 32'h0;
    MemRead_i = rd; MemWrite_i = wr; addr_i = a; data_i = d;
    for (int c = 0; c <= lat + 1; c++) begin
      mem_ack_i   = (ack_at >= 1) && (c == ack_at);
      mem_rdata_i = (c == ack_at) ? rdv : $urandom;
      if (c == ack_at) ack_data = mem_rdata_i;
      @(negedge clk_i);
      e_stall = (c <= lat);
      e_req   = (c >= 1) && (c <= lat);
      e_valid = (c == lat + 1);
      e_bub   = load_use() && !e_stall;
      if (e_valid) begin
        if (tmo) begin model_err = 1'b1; model_rdata = 32'h0; end
        else if (!wr) model_rdata = ack_data;
      end
      checks++;
      if (stall_o !== e_stall) begin
        errors++; $display("FAIL stall c=%0d: got %b expected %b", c, stall_o, e_stall);
      end
      checks++;
      if (mem_req_o !== e_req) begin
        errors++; $display("FAIL req c=%0d: got %b expected %b", c, mem_req_o, e_req);
      end
      checks++;
      if (mem_valid_o !== e_valid) begin
        errors++; $display("FAIL valid c=%0d: got %b expected %b", c, mem_valid_o, e_valid);
      end
      checks++;
      if (bubble_o !== e_bub || hold_o !== (e_bub || e_stall)) begin
        errors++; $display("FAIL bubble/hold c=%0d: got %b/%b expected %b/%b",
                           c, bubble_o, hold_o, e_bub, e_bub || e_stall);
      end
      checks++;
      if (rdata_o !== model_rdata || err_o !== model_err) begin
        errors++; $display("FAIL rdata/err c=%0d: got %h/%b expected %h/%b",
                           c, rdata_o, err_o, model_rdata, model_err);
      end
      if (e_req) begin
        checks++;
        if (mem_addr_o !== a || mem_wdata_o !== d || mem_we_o !== wr) begin
          errors++; $display("FAIL latch c=%0d: got %h/%h/%b expected %h/%h/%b",
                             c, mem_addr_o, mem_wdata_o, mem_we_o, a, d, wr);
        end
      end
      @(posedge clk_i); #1;
    end
    mem_ack_i = 1'b0;
  endtask

  // A cycle with no memory instruction in EX/MEM; an optional stray ack.
  task automatic idle_cycle(input bit ack);
    bit e_bub;
    MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = ack; mem_rdata_i = $urandom;
    @(negedge clk_i);
    e_bub = load_use();
    checks++;
    if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || mem_valid_o !== 1'b0) begin
      errors++; $display("FAIL idle: got stall/req/valid %b/%b/%b expected 0/0/0",
                         stall_o, mem_req_o, mem_valid_o);
    end
    checks++;
    if (bubble_o !== e_bub || hold_o !== e_bub) begin
      errors++; $display("FAIL idle bubble/hold: got %b/%b expected %b/%b",
                         bubble_o, hold_o, e_bub, e_bub);
    end
    checks++;
    if (rdata_o !== model_rdata || err_o !== model_err) begin
      errors++; $display("FAIL idle rdata/err: got %h/%b expected %h/%b",
                         rdata_o, err_o, model_rdata, model_err);
    end
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    MemRead_i = 1'b1; MemWrite_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    IDEX_MemRead_i = 1'b0; IDEX_RD_i = 5'd0; IFID_RS1_i = 5'd0; IFID_RS2_i = 5'd0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({mem_req_o, mem_we_o, mem_valid_o, err_o} !== 4'b0 ||
        mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || rdata_o !== 32'h0) begin
      errors++; $display("FAIL reset values: got req=%b we=%b valid=%b err=%b addr=%h wdata=%h rdata=%h expected all 0",
                         mem_req_o, mem_we_o, mem_valid_o, err_o, mem_addr_o, mem_wdata_o, rdata_o);
    end
    checks++;
    if (stall_o !== 1'b1 || hold_o !== 1'b1) begin
      errors++; $display("FAIL reset stall with access: got %b/%b expected 1/1", stall_o, hold_o);
    end
    MemRead_i = 1'b0;
    rst_i = 1'b0;
    model_rdata = 32'h0; model_err = 1'b0;
    @(posedge clk_i); #1;
    idle_cycle(1'b1);
  endtask

  task automatic test_load_store();
    run_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF);
    idle_cycle(1'b0);
    checks++;
    if (rdata_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load data: got %h expected deadbeef", rdata_o);
    end
    run_access(1'b0, 1'b1, 32'h80, 32'h12345678, 4, 32'hA5A5A5A5);
    idle_cycle(1'b0);
    run_access(1'b1, 1'b1, 32'hC4, 32'hCAFEF00D, 2, 32'h11111111);
    idle_cycle(1'b1);
  endtask

  task automatic test_hazard();
    IDEX_MemRead_i = 1'b1; IDEX_RD_i = 5'd5; IFID_RS1_i = 5'd0; IFID_RS2_i = 5'd5;
    idle_cycle(1'b0);
    checks++;
    if (bubble_o !== 1'b1 || hold_o !== 1'b1) begin
      errors++; $display("FAIL load-use rs2: got %b/%b expected 1/1", bubble_o, hold_o);
    end
    IDEX_RD_i = 5'd0; IFID_RS2_i = 5'd0;
    idle_cycle(1'b0);
    checks++;
    if (bubble_o !== 1'b0) begin
      errors++; $display("FAIL load-use x0: got %b expected 0", bubble_o);
    end
    IDEX_RD_i = 5'd5; IFID_RS2_i = 5'd5;
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'h0BADF00D);
    for (int i = 0; i < 30; i++) begin
      IDEX_MemRead_i = 1'($urandom);
      IDEX_RD_i  = 5'($urandom_range(0, 3));
      IFID_RS1_i = 5'($urandom_range(0, 3));
      IFID_RS2_i = 5'($urandom_range(0, 3));
      idle_cycle(1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    IDEX_MemRead_i = 1'b0;
    run_access(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h01020304);
    run_access(1'b1, 1'b0, 32'h204, 32'h0, 1, 32'h05060708);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h0);
    idle_cycle(1'b1);
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL timeout err sticky: got %b expected 1", err_o);
    end
    run_access(1'b1, 1'b0, 32'h304, 32'h0, 2, 32'h77778888);
    idle_cycle(1'b0);
  endtask

  task automatic test_random();
    bit rd, wr;
    for (int i = 0; i < 25; i++) begin
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      IDEX_MemRead_i = 1'($urandom);
      IDEX_RD_i  = 5'($urandom_range(0, 3));
      IFID_RS1_i = 5'($urandom_range(0, 3));
      IFID_RS2_i = 5'($urandom_range(0, 3));
      run_access(rd, wr, $urandom, $urandom, int'($urandom_range(1, T + 2)), $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycle(1'($urandom));
    end
  endtask

  task automatic test_reset_mid_busy();
    MemRead_i = 1'b1; MemWrite_i = 1'b0; addr_i = 32'h400;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++; $display("FAIL pre-reset req: got %b expected 1", mem_req_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || mem_valid_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'h0) begin
      errors++; $display("FAIL async reset: got req=%b valid=%b err=%b rdata=%h expected 0",
                         mem_req_o, mem_valid_o, err_o, rdata_o);
    end
    MemRead_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL reset state idle: got stall %b expected 0", stall_o);
    end
    rst_i = 1'b0;
    model_rdata = 32'h0; model_err = 1'b0;
    @(posedge clk_i); #1;
    for (int i = 0; i < 3; i++) idle_cycle(1'b1);
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_hazard();
    test_back_to_back();
    test_timeout();
    test_random();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
